// File: rtl/ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_pkg
// Shared definitions for the hardwired control-step sequencer:
//   - default opcode values and widths (used as parameter defaults)
//   - 3-bit state encodings IDLE,T0,T1,T1W,T2,T3,HALT
//   - decode result structure produced by mfx_decode
// ---------------------------------------------------------------------------
package ctrl_pkg;

  localparam int DEF_OP_W    = 5;
  localparam int DEF_MFHI_OP = 27;
  localparam int DEF_MFLO_OP = 28;
  localparam int DEF_NOP_OP  = 0;
  localparam int DEF_HALT_OP = 31;
  localparam int DEF_TMO_W   = 4;
  localparam int DEF_MEM_TMO = 8;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_T0   = 3'd1;
  localparam logic [2:0] ST_T1   = 3'd2;
  localparam logic [2:0] ST_T1W  = 3'd3;
  localparam logic [2:0] ST_T2   = 3'd4;
  localparam logic [2:0] ST_T3   = 3'd5;
  localparam logic [2:0] ST_HALT = 3'd6;

  typedef struct packed {
    logic gra;
    logic rin;
    logic hiout;
    logic loout;
    logic illegal;
    logic is_halt;
  } dec_t;

endpackage

// File: rtl/mfx_decode.sv
// ---------------------------------------------------------------------------
// mfx_decode
// Combinational opcode decoder for the T3 execute step.
// Ports:
//   en_i     in  1     high only while the sequencer is in T3
//   opcode_i in  OP_W  IR opcode field
//   dec_o    out dec_t {gra, rin, hiout, loout, illegal, is_halt}
// With en_i low every field is 0, so nothing can leak outside T3.
// ---------------------------------------------------------------------------
module mfx_decode
  import ctrl_pkg::*;
#(
  parameter int OP_W    = DEF_OP_W,
  parameter int MFHI_OP = DEF_MFHI_OP,
  parameter int MFLO_OP = DEF_MFLO_OP,
  parameter int NOP_OP  = DEF_NOP_OP,
  parameter int HALT_OP = DEF_HALT_OP
) (
  input  logic            en_i,
  input  logic [OP_W-1:0] opcode_i,
  output dec_t            dec_o
);

  always_comb begin
    dec_o = '0;
    if (en_i) begin
      if (opcode_i == OP_W'(MFHI_OP)) begin
        dec_o.gra   = 1'b1;
        dec_o.rin   = 1'b1;
        dec_o.hiout = 1'b1;
      end else if (opcode_i == OP_W'(MFLO_OP)) begin
        dec_o.gra   = 1'b1;
        dec_o.rin   = 1'b1;
        dec_o.loout = 1'b1;
      end else if (opcode_i == OP_W'(NOP_OP)) begin
        dec_o = '0;
      end else if (opcode_i == OP_W'(HALT_OP)) begin
        dec_o.is_halt = 1'b1;
      end else begin
        // Undefined opcode: flag it, write nothing.
        dec_o.illegal = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mfx_ctrl_seq.sv
// ---------------------------------------------------------------------------
// mfx_ctrl_seq
// Hardwired control-step sequencer: fetch (T0,T1,T1W,T2) followed by a
// single execute step T3 for mfhi / mflo / nop / halt.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   run                 1 = keep fetching, 0 = finish current instr then IDLE
//   opcode              IR opcode field, looked at in T3 only
//   mem_ready           memory data valid for MDR this cycle
//   PCout..LOout        datapath control strobes (one group per step)
//   busy                not IDLE and not HALT
//   halted              state is HALT
//   illegal             T3 pulse for an undefined opcode
//   mem_err             sticky memory-timeout flag
//   step                current state encoding
// ---------------------------------------------------------------------------
module mfx_ctrl_seq
  import ctrl_pkg::*;
#(
  parameter int OP_W    = DEF_OP_W,
  parameter int MFHI_OP = DEF_MFHI_OP,
  parameter int MFLO_OP = DEF_MFLO_OP,
  parameter int NOP_OP  = DEF_NOP_OP,
  parameter int HALT_OP = DEF_HALT_OP,
  parameter int TMO_W   = DEF_TMO_W,
  parameter int MEM_TMO = DEF_MEM_TMO
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  input  logic [OP_W-1:0] opcode,
  input  logic            mem_ready,
  output logic            PCout,
  output logic            MARin,
  output logic            IncPC,
  output logic            Zin,
  output logic            Zlowout,
  output logic            PCin,
  output logic            Read,
  output logic            MDRin,
  output logic            MDRout,
  output logic            IRin,
  output logic            Gra,
  output logic            Rin,
  output logic            HIout,
  output logic            LOout,
  output logic            busy,
  output logic            halted,
  output logic            illegal,
  output logic            mem_err,
  output logic [2:0]      step
);

  logic [2:0]       state_q, state_d;
  logic [TMO_W-1:0] cnt_q, cnt_d;
  logic             mem_err_q, mem_err_d;
  dec_t             dec;

  mfx_decode #(
    .OP_W    (OP_W),
    .MFHI_OP (MFHI_OP),
    .MFLO_OP (MFLO_OP),
    .NOP_OP  (NOP_OP),
    .HALT_OP (HALT_OP)
  ) u_decode (
    .en_i     (state_q == ST_T3),
    .opcode_i (opcode),
    .dec_o    (dec)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_err_d = mem_err_q;
    case (state_q)
      ST_IDLE: if (run) state_d = ST_T0;
      ST_T0:   state_d = ST_T1;
      ST_T1: begin
        state_d = ST_T1W;
        cnt_d   = '0;
      end
      ST_T1W: begin
        // cnt_q counts T1W cycles already spent without data; ready on the
        // same cycle as the last allowed one still wins over the timeout.
        if (mem_ready) begin
          state_d = ST_T2;
          cnt_d   = '0;
        end else if (cnt_q == TMO_W'(MEM_TMO - 1)) begin
          state_d   = ST_HALT;
          mem_err_d = 1'b1;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + TMO_W'(1);
        end
      end
      ST_T2:   state_d = ST_T3;
      ST_T3: begin
        if (dec.is_halt) state_d = ST_HALT;
        else             state_d = run ? ST_T0 : ST_IDLE;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mem_err_q <= mem_err_d;
    end
  end

  // Strobes follow the registered state; the T3 group also depends on the
  // decoded opcode, which is forced to zero outside T3.
  assign PCout   = (state_q == ST_T0);
  assign MARin   = (state_q == ST_T0);
  assign IncPC   = (state_q == ST_T0);
  assign Zin     = (state_q == ST_T0);
  assign Zlowout = (state_q == ST_T1);
  assign PCin    = (state_q == ST_T1);
  assign Read    = (state_q == ST_T1W);
  assign MDRin   = (state_q == ST_T1W);
  assign MDRout  = (state_q == ST_T2);
  assign IRin    = (state_q == ST_T2);
  assign Gra     = dec.gra;
  assign Rin     = dec.rin;
  assign HIout   = dec.hiout;
  assign LOout   = dec.loout;
  assign illegal = dec.illegal;

  assign busy    = (state_q != ST_IDLE) && (state_q != ST_HALT);
  assign halted  = (state_q == ST_HALT);
  assign mem_err = mem_err_q;
  assign step    = state_q;

endmodule

// File: tb/tb_mfx_ctrl_seq.sv
// ---------------------------------------------------------------------------
// tb_mfx_ctrl_seq
// Directed bench for mfx_ctrl_seq with a tiny proc datapath model
// (PC, Z, R2, HI=100, LO=10) driven by the sequencer strobes.
// ---------------------------------------------------------------------------
module tb_mfx_ctrl_seq;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_T0   = 3'd1;
  localparam logic [2:0] S_T1   = 3'd2;
  localparam logic [2:0] S_T1W  = 3'd3;
  localparam logic [2:0] S_T2   = 3'd4;
  localparam logic [2:0] S_T3   = 3'd5;
  localparam logic [2:0] S_HALT = 3'd6;

  // Strobe vector bit order:
  // PCout MARin IncPC Zin Zlowout PCin Read MDRin MDRout IRin Gra Rin HIout LOout
  localparam logic [13:0] P_T0  = 14'h3C00;
  localparam logic [13:0] P_T1  = 14'h0300;
  localparam logic [13:0] P_T1W = 14'h00C0;
  localparam logic [13:0] P_T2  = 14'h0030;
  localparam logic [13:0] P_HI  = 14'h000E;
  localparam logic [13:0] P_LO  = 14'h000D;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       run = 1'b0;
  logic [4:0] opcode = 5'd27;
  logic       mem_ready = 1'b1;
  logic PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, MDRin;
  logic MDRout, IRin, Gra, Rin, HIout, LOout;
  logic busy, halted, illegal, mem_err;
  logic [2:0] step;
  logic [13:0] strb;

  int checks = 0;
  int errors = 0;

  // proc model
  int pc = 7;
  int z  = 0;
  int r2 = 0;
  localparam int HI_VAL = 100;
  localparam int LO_VAL = 10;

  always #5 clk = ~clk;

  mfx_ctrl_seq dut (
    .clk(clk), .reset(reset), .run(run), .opcode(opcode), .mem_ready(mem_ready),
    .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Zin(Zin),
    .Zlowout(Zlowout), .PCin(PCin), .Read(Read), .MDRin(MDRin),
    .MDRout(MDRout), .IRin(IRin), .Gra(Gra), .Rin(Rin),
    .HIout(HIout), .LOout(LOout), .busy(busy), .halted(halted),
    .illegal(illegal), .mem_err(mem_err), .step(step)
  );

  assign strb = {PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, MDRin,
                 MDRout, IRin, Gra, Rin, HIout, LOout};

  always @(posedge clk) begin
    if (IncPC && Zin) z <= pc + 1;
    if (Zlowout && PCin) pc <= z;
    if (Gra && Rin && HIout) r2 <= HI_VAL;
    else if (Gra && Rin && LOout) r2 <= LO_VAL;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_to(input string tag, input logic [2:0] tgt, input int lim);
    bit hit = 0;
    for (int i = 0; i < lim && !hit; i++) begin
      tick();
      if (step == tgt) hit = 1;
    end
    chk(tag, {29'd0, step}, {29'd0, tgt});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int rd_cnt, pcin_cnt, busy_cnt, w, rin_seen;

    // Reset state
    do_reset();
    chk("rst_step", {29'd0, step}, {29'd0, S_IDLE});
    chk("rst_strb", {18'd0, strb}, 32'd0);
    chk("rst_flags", {28'd0, busy, halted, illegal, mem_err}, 32'd0);

    // 1: mfhi with zero wait states
    run = 1'b1; opcode = 5'd27; mem_ready = 1'b1;
    tick(); chk("t1_T0", {15'd0, step, strb}, {15'd0, S_T0, P_T0});
    tick(); chk("t1_T1", {15'd0, step, strb}, {15'd0, S_T1, P_T1});
    tick(); chk("t1_T1W", {15'd0, step, strb}, {15'd0, S_T1W, P_T1W});
    tick(); chk("t1_T2", {15'd0, step, strb}, {15'd0, S_T2, P_T2});
    tick(); chk("t1_T3", {15'd0, step, strb}, {15'd0, S_T3, P_HI});
    run = 1'b0;
    tick(); chk("t1_idle", {29'd0, step}, {29'd0, S_IDLE});
    chk("t1_r2", r2, 32'd100);
    chk("t1_pc", pc, 32'd8);
    $display("txn 1 mfhi r2=%0d pc=%0d", r2, pc);

    // 2: mflo
    run = 1'b1; opcode = 5'd28;
    run_to("t2_reach", S_T3, 10);
    chk("t2_T3", {18'd0, strb}, {18'd0, P_LO});
    run = 1'b0;
    tick(); chk("t2_idle", {29'd0, step}, {29'd0, S_IDLE});
    chk("t2_r2", r2, 32'd10);
    chk("t2_pc", pc, 32'd9);
    $display("txn 2 mflo r2=%0d pc=%0d", r2, pc);

    // 3: nop with 3 wait states
    run = 1'b1; opcode = 5'd0; mem_ready = 1'b0;
    rd_cnt = 0; pcin_cnt = 0; busy_cnt = 0; w = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (step == S_IDLE) break;
      busy_cnt++;
      if (Read) rd_cnt++;
      if (PCin) pcin_cnt++;
      if (step == S_T1W) begin
        w++;
        if (w == 4) mem_ready = 1'b1;
      end
      if (step == S_T3) begin
        run = 1'b0;
        chk("t3_nop_strb", {18'd0, strb}, 32'd0);
      end
    end
    chk("t3_read_cnt", rd_cnt, 32'd4);
    chk("t3_pcin_cnt", pcin_cnt, 32'd1);
    chk("t3_latency", busy_cnt, 32'd8);
    $display("txn 3 nop wait=3 read=%0d cycles=%0d", rd_cnt, busy_cnt);

    // 4: memory timeout
    run = 1'b1; opcode = 5'd27; mem_ready = 1'b0;
    w = 0; rin_seen = 0;
    for (int i = 0; i < 40 && !halted; i++) begin
      tick();
      if (step == S_T1W) w++;
      if (Rin) rin_seen = 1;
    end
    chk("t4_t1w_cnt", w, 32'd8);
    chk("t4_flags", {30'd0, halted, mem_err}, 32'd3);
    chk("t4_rin", rin_seen, 32'd0);
    run = 1'b0; mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (Rin) rin_seen = 1;
    end
    chk("t4_sticky", {27'd0, step, halted, mem_err}, {27'd0, S_HALT, 2'b11});
    chk("t4_rin_after", rin_seen, 32'd0);
    do_reset();
    chk("t4_reset", {27'd0, step, halted, mem_err}, {27'd0, S_IDLE, 2'b00});
    $display("txn 4 timeout t1w=%0d", w);

    // 5: illegal opcode, then halt
    run = 1'b1; opcode = 5'd9; mem_ready = 1'b1;
    run_to("t5_reach_ill", S_T3, 10);
    chk("t5_illegal", {18'd0, illegal, strb}, {18'd0, 1'b1, 14'd0});
    tick();
    chk("t5_next", {28'd0, step, illegal}, {28'd0, S_T0, 1'b0});
    opcode = 5'd31;
    run_to("t5_reach_halt", S_T3, 10);
    chk("t5_halt_T3", {18'd0, illegal, strb}, 32'd0);
    tick();
    chk("t5_halted", {27'd0, step, halted, busy}, {27'd0, S_HALT, 2'b10});
    run = 1'b0;
    tick(); tick(); tick();
    chk("t5_stay", {29'd0, step}, {29'd0, S_HALT});
    chk("t5_no_memerr", {31'd0, mem_err}, 32'd0);
    $display("txn 5 illegal+halt step=%0d", step);
    do_reset();

    // 6a: reset in T1W
    run = 1'b1; opcode = 5'd27; mem_ready = 1'b0;
    run_to("t6_reach_t1w", S_T1W, 10);
    reset = 1'b1;
    tick();
    chk("t6_rst_idle", {15'd0, step, strb}, {15'd0, S_IDLE, 14'd0});
    reset = 1'b0; run = 1'b0;
    tick();
    chk("t6_rst_r2", r2, 32'd10);
    chk("t6_rst_stay", {29'd0, step}, {29'd0, S_IDLE});

    // 6b: run dropped in T2, instruction still completes
    run = 1'b1; mem_ready = 1'b1;
    run_to("t6_reach_t2", S_T2, 10);
    run = 1'b0;
    tick();
    chk("t6_run_T3", {15'd0, step, strb}, {15'd0, S_T3, P_HI});
    tick();
    chk("t6_run_idle", {29'd0, step}, {29'd0, S_IDLE});
    chk("t6_run_r2", r2, 32'd100);
    $display("txn 6 reset/run-drop r2=%0d", r2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
